// File: rtl/bin_to_bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Inputs above 10^DIGITS-1 saturate to all nines and raise overflow.
module bin_to_bcd_serial #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int SCR_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_DEC = (longint'(10) ** DIGITS) - 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [SCR_W-1:0]    scr_q, scr_d, adj;
  logic                ovf_lat_q, ovf_lat_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  // All nibbles are corrected from their pre-adjust values in parallel.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    scr_d     = scr_q;
    ovf_lat_d = ovf_lat_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scr_d     = '0;
          ovf_lat_d = (64'(bin_in) > MAX_DEC);
          cnt_d     = CNT_W'(BIN_W);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scr_d = (adj << 1) | SCR_W'(bin_q[BIN_W-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          ovf_d   = ovf_lat_q;
          bcd_d   = ovf_lat_q ? {DIGITS{4'h9}} : scr_d[4*DIGITS-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      scr_q     <= '0;
      ovf_lat_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      scr_q     <= scr_d;
      ovf_lat_q <= ovf_lat_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: doc/bin_to_bcd_serial.md
# bin_to_bcd_serial

Sequential binary-to-BCD converter (shift-and-add-3) that turns a 20-bit unsigned binary result into six packed BCD digits for the six-digit seven-segment display path. It sits between binary arithmetic blocks and the per-digit `seven_seg_driver` instances. It is the reverse of the keypad entry path, which assembles decimal digits into a register. It uses a start/busy/done handshake, so one converter can be shared by several producers.

## Interface
- `BIN_W`, 20: binary input width; must satisfy 2^BIN_W ≥ 10^DIGITS − 1 headroom check below.
- `DIGITS`, 6: number of BCD output digits; output width is 4·DIGITS.
- `CLOCK_50`  in  1  system clock, 50 MHz; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while idle.
- `bin_in`  in  BIN_W  unsigned value, captured on the accepting edge.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bcd_out` is updated.
- `bcd_out`  out  4·DIGITS  packed BCD, digit 0 in bits [3:0]; holds the last result.
- `overflow`  out  1  set with `done` when input exceeded 10^DIGITS − 1; holds until the next `done`.

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - If `start`=1, capture `bin_in` into the shift register and clear the BCD scratch register.
  - Compute overflow = (`bin_in` > 999999), latched internally.
  - Load counter = BIN_W, go to SHIFT, and drive `busy`=1.
  - If `start`=0, stay in IDLE.
- SHIFT, each cycle:
  - Any scratch nibble ≥ 5 gets +3. All nibbles are adjusted in parallel from the pre-adjust values.
  - Then shift {scratch, binary} left by one.
  - Decrement the counter.
- On the edge that performs the final (BIN_W-th) shift:
  - `bcd_out` ← adjusted-and-shifted scratch, or 24'h999999 if overflow.
  - `overflow` ← latched flag.
  - `done` ← 1, `busy` ← 0, next state IDLE.
- `start` during SHIFT is ignored and not queued.
- `bin_in` changes after capture have no effect.
- The nibble adjust applies to all DIGITS nibbles. The scratch register is 4·DIGITS+4 bits wide, so an overflowing input does not corrupt the saturated result. Extra high bits are discarded.
- `done` is high for exactly one cycle per accepted start.
- Reset (synchronous, any state):
  - State IDLE, counter 0.
  - `busy`=0, `done`=0, `overflow`=0, `bcd_out`=0.
  - An in-flight conversion is aborted and never produces `done`.
- If reset and start are both high on the same edge, reset wins and nothing is captured.

## Timing
- Start accepted at edge k; `busy`=1 from edge k.
- Shifts occur at edges k+1 … k+BIN_W.
- `done`=1, `busy`=0 and `bcd_out` valid after edge k+BIN_W. With defaults this is 20 cycles after acceptance.
- In the `done` cycle the FSM is already IDLE, so a `start` held high there is accepted at edge k+BIN_W+1.
- Maximum throughput is one conversion per BIN_W+1 cycles (21 with defaults).
- `bcd_out` and `overflow` change only on `done` or on reset.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start with `bin_in`=0:
  - `done` 20 cycles after acceptance.
  - `bcd_out`=24'h000000, `overflow`=0.
- `bin_in`=123456 (20'h1E240):
  - `bcd_out`=24'h123456 exactly 20 cycles after the accepting edge.
  - `busy` high for those 20 cycles, `done` width 1.
- `bin_in`=999999 (20'hF423F) gives `bcd_out`=24'h999999, `overflow`=0.
- `bin_in`=1000000 (20'hF4240) gives `bcd_out`=24'h999999, `overflow`=1.
- A following start with 42 gives `bcd_out`=24'h000042 and `overflow` back to 0.
- Start 500 (20'h001F4):
  - Pulse `start` with `bin_in`=7 at cycle 5 mid-conversion; that pulse is ignored and the result is 24'h000500.
  - Hold `start`=1 with `bin_in`=9 through the `done` cycle; the next conversion is accepted at edge k+21 and yields 24'h000009.
- Start 777777, then assert `reset` at cycle 10:
  - No `done` ever appears.
  - `busy`=0 and `bcd_out`=0 after the reset edge.
  - A subsequent start with 31 yields 24'h000031.
